// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage in front of the CPU core. Owns the fetch PC, issues
// word requests to instruction memory (valid/ready request, in-order response
// with no backpressure), buffers returned words in a small prefetch FIFO and
// presents Instr/PC pairs to the core. A jump redirect flushes the FIFO and
// marks every request still in flight as stale so that its response is dropped.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//   FIFO_DEPTH      prefetch FIFO entries (power of two, 2..8)
//   MAX_OUTSTANDING max accepted-but-unanswered requests (<= FIFO_DEPTH)
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   pc_redirect           single-cycle jump pulse from the core
//   redirect_addr[31:0]   jump target (low two bits ignored)
//   imem_req_valid/ready  request handshake to instruction memory
//   imem_req_addr[31:0]   word-aligned request address
//   imem_rsp_valid        in-order response strobe
//   imem_rsp_data[31:0]   returned instruction word
//   instr_valid/ready     handshake towards the core
//   instr[31:0]           instruction word (NOP when the FIFO is empty)
//   instr_pc[31:0]        address of instr
//
// Optional build macro IFU_PERF_CNT_EN adds two saturating counters:
//   perf_stall_cnt[31:0]   cycles with a blocked request or spent in STALL
//   perf_discard_cnt[31:0] responses thrown away because of a redirect
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int Q_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAXO_L  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [Q_W-1:0]   Q_LAST  = Q_W'(MAX_OUTSTANDING - 1);
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [31:0]      PC_INIT = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]      r_fetch_pc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_outst;
  logic [CNT_W-1:0] r_discard;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [Q_W-1:0]   r_q_wr;
  logic [Q_W-1:0]   r_q_rd;

  // Storage arrays: no reset needed, validity is tracked by counters.
  logic [31:0] r_fifo_instr [FIFO_DEPTH];
  logic [31:0] r_fifo_pc    [FIFO_DEPTH];
  logic [31:0] r_pcq        [MAX_OUTSTANDING];

  logic             w_accept;
  logic             w_rsp;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_credit;
  logic [CNT_W:0]   w_inflight;
  logic [CNT_W-1:0] w_outst_next;
  logic [31:0]      w_redirect_pc;

  assign w_redirect_pc = redirect_addr & 32'hFFFF_FFFC;

  assign w_accept = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp    = imem_rsp_valid & (r_outst != '0);
  assign w_drop   = w_rsp & (r_discard != '0);
  // A live response arriving in the redirect cycle belongs to the old stream,
  // so the flush wins over the push.
  assign w_push   = w_rsp & ~w_drop & ~pc_redirect;
  assign w_pop    = instr_valid & instr_ready;
  assign w_empty  = (r_count == '0);

  // Every live request in flight already owns a FIFO slot; stale ones do not,
  // because their responses never reach the FIFO.
  assign w_inflight   = {1'b0, r_count} + {1'b0, r_outst} - {1'b0, r_discard};
  assign w_credit     = (w_inflight < DEPTH_L) && (r_outst < MAXO_L);
  assign w_outst_next = r_outst + CNT_W'(w_accept) - CNT_W'(w_rsp);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    imem_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req_valid = w_credit;
        if (!w_credit) begin
          w_state_next = S_STALL;
        end
      end
      S_STALL: begin
        if (w_credit) begin
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (pc_redirect && (r_state != S_IDLE)) begin
      w_state_next = S_FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // PC, counters and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= PC_INIT;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
    end else begin
      r_outst <= w_outst_next;

      // The PC queue follows the memory's in-order stream, stale or not.
      if (w_accept) begin
        r_q_wr <= (r_q_wr == Q_LAST) ? '0 : r_q_wr + Q_W'(1);
      end
      if (w_rsp) begin
        r_q_rd <= (r_q_rd == Q_LAST) ? '0 : r_q_rd + Q_W'(1);
      end

      if (pc_redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        // Everything still in flight after this cycle, including a request
        // accepted right now, belongs to the abandoned stream.
        r_discard  <= w_outst_next;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_drop) begin
          r_discard <= r_discard - CNT_W'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pcq[r_q_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]    <= r_pcq[r_q_rd];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req_addr = r_fetch_pc;
  // The head must not be offered to the core in the cycle it is being flushed.
  assign instr_valid   = ~w_empty & ~pc_redirect;
  assign instr         = w_empty ? NOP   : r_fifo_instr[r_rd_ptr];
  assign instr_pc      = w_empty ? 32'd0 : r_fifo_pc[r_rd_ptr];

`ifdef IFU_PERF_CNT_EN
  logic w_stall_evt;
  logic w_discard_evt;

  assign w_stall_evt   = (imem_req_valid & ~imem_req_ready) | (r_state == S_STALL);
  assign w_discard_evt = w_rsp & (w_drop | pc_redirect);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if (w_stall_evt && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (w_discard_evt && (perf_discard_cnt != 32'hFFFF_FFFF)) begin
        perf_discard_cnt <= perf_discard_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
